// File: rtl/mem_channel_responder.sv
// -----------------------------------------------------------------------------
// mem_channel_responder
//
// Memory-side responder for one read/write memory channel. A synchronous,
// word-addressed backing store answers the read and write channels. Each
// channel has its own fixed latency, and the two channels run independently,
// so a read and a write may be in flight at the same time.
//
// Each channel runs a small IDLE -> BUSY -> RESP machine and uses a four-phase
// handshake:
//   - The request is captured from IDLE on the first edge where valid is 1.
//   - ready rises exactly LAT edges after the capture edge.
//   - ready falls on the first edge where valid is sampled 0.
//
// Ports
//   clk            in   1          single clock, rising edge
//   reset_n        in   1          asynchronous assert, active-low reset
//   read_valid     in   1          read request, held until read_ready seen
//   read_address   in   ADDR_BITS  read word address, sampled at capture
//   read_ready     out  1          read response valid
//   read_data      out  DATA_BITS  read result, held until the next read completes
//   write_valid    in   1          write request, held until write_ready seen
//   write_address  in   ADDR_BITS  write word address, sampled at capture
//   write_data     in   DATA_BITS  write data, sampled at capture
//   write_ready    out  1          write committed acknowledge
// -----------------------------------------------------------------------------
module mem_channel_responder #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  output logic                 read_ready,
  output logic [DATA_BITS-1:0] read_data,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 write_ready
);

  localparam int IDX_BITS = $clog2(DEPTH);

  // The counter holds LAT-1 at most. It is kept at least one bit wide so that
  // LAT=1 still compiles.
  localparam int RCW = (READ_LATENCY  > 1) ? $clog2(READ_LATENCY)  : 1;
  localparam int WCW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam logic [RCW-1:0] RCNT_INIT = RCW'(READ_LATENCY - 1);
  localparam logic [WCW-1:0] WCNT_INIT = WCW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Backing store
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Read channel state
  state_e               rd_state_q;
  logic [RCW-1:0]       rd_cnt_q;
  logic [IDX_BITS-1:0]  rd_idx_q;
  logic                 read_ready_q;
  logic [DATA_BITS-1:0] read_data_q;

  // Write channel state
  state_e               wr_state_q;
  logic [WCW-1:0]       wr_cnt_q;
  logic [IDX_BITS-1:0]  wr_idx_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 write_ready_q;

  logic                 wr_commit;

  // Upper address bits are ignored on purpose, so addresses wrap around.
  // This folds them into one signal that is deliberately left unused.
  if (ADDR_BITS > IDX_BITS) begin : g_addr_wrap
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_address[ADDR_BITS-1:IDX_BITS],
                                write_address[ADDR_BITS-1:IDX_BITS]};
  end

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only. Every
  // flop then samples pre-edge values, which is what makes a same-edge read see
  // the old memory word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q   <= ST_IDLE;
      rd_cnt_q     <= '0;
      rd_idx_q     <= '0;
      read_ready_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      case (rd_state_q)
        ST_IDLE: begin
          if (read_valid) begin
            rd_idx_q   <= read_address[IDX_BITS-1:0];
            rd_cnt_q   <= RCNT_INIT;
            rd_state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The access completes even if valid drops here (a protocol
          // violation). RESP then sees valid=0 and ready pulses for one cycle.
          if (rd_cnt_q != '0) begin
            rd_cnt_q <= rd_cnt_q - 1'b1;
          end else begin
            read_data_q  <= mem_q[rd_idx_q];
            read_ready_q <= 1'b1;
            rd_state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!read_valid) begin
            read_ready_q <= 1'b0;
            rd_state_q   <= ST_IDLE;
          end
        end
        default: rd_state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q    <= ST_IDLE;
      wr_cnt_q      <= '0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      write_ready_q <= 1'b0;
    end else begin
      case (wr_state_q)
        ST_IDLE: begin
          if (write_valid) begin
            wr_idx_q   <= write_address[IDX_BITS-1:0];
            wr_data_q  <= write_data;
            wr_cnt_q   <= WCNT_INIT;
            wr_state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wr_cnt_q != '0) begin
            wr_cnt_q <= wr_cnt_q - 1'b1;
          end else begin
            write_ready_q <= 1'b1;
            wr_state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!write_valid) begin
            write_ready_q <= 1'b0;
            wr_state_q    <= ST_IDLE;
          end
        end
        default: wr_state_q <= ST_IDLE;
      endcase
    end
  end

  // The commit happens on the BUSY->RESP edge. Reset forces the FSM to IDLE,
  // so a write that is in flight during reset is never committed.
  assign wr_commit = (wr_state_q == ST_BUSY) && (wr_cnt_q == '0);

  // NOTE: the memory array has no reset. Its contents survive reset_n, and
  // leaving it out of the reset lets the array map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[wr_idx_q] <= wr_data_q;
    end
  end

  assign read_ready  = read_ready_q;
  assign read_data   = read_data_q;
  assign write_ready = write_ready_q;

endmodule

// File: tb/tb_mem_channel_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_channel_responder
//
// Three responder instances with different latency settings share one clock
// and one reset:
//   inst 0 : READ_LATENCY=2, WRITE_LATENCY=1 (defaults)
//   inst 1 : READ_LATENCY=4, WRITE_LATENCY=1
//   inst 2 : READ_LATENCY=2, WRITE_LATENCY=2
//
// A word-level reference store per instance holds the expected memory
// contents. Expected handshake timing comes from the configured latencies.
// -----------------------------------------------------------------------------
module tb_mem_channel_responder;

  logic        clk;
  logic        reset_n;
  logic        rv [3];
  logic [31:0] ra [3];
  logic        rr [3];
  logic [31:0] rd [3];
  logic        wv [3];
  logic [31:0] wa [3];
  logic [31:0] wd [3];
  logic        wr [3];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected word per instance and index, plus a written flag.
  logic [31:0] model [3][256];
  bit          known [3][256];

  mem_channel_responder #(.READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .read_valid(rv[0]), .read_address(ra[0]), .read_ready(rr[0]), .read_data(rd[0]),
    .write_valid(wv[0]), .write_address(wa[0]), .write_data(wd[0]), .write_ready(wr[0])
  );

  mem_channel_responder #(.READ_LATENCY(4), .WRITE_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .read_valid(rv[1]), .read_address(ra[1]), .read_ready(rr[1]), .read_data(rd[1]),
    .write_valid(wv[1]), .write_address(wa[1]), .write_data(wd[1]), .write_ready(wr[1])
  );

  mem_channel_responder #(.READ_LATENCY(2), .WRITE_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .read_valid(rv[2]), .read_address(ra[2]), .read_ready(rr[2]), .read_data(rd[2]),
    .write_valid(wv[2]), .write_address(wa[2]), .write_data(wd[2]), .write_ready(wr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rlat(input int inst);
    return (inst == 1) ? 4 : 2;
  endfunction

  function automatic int wlat(input int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write transaction. The request is captured on the first posedge.
  // ready must stay low for lat-1 edges and then rise. It must stay high
  // through 'hold' extra cycles and fall on the edge after valid drops.
  task automatic write_txn(input int inst, input logic [31:0] addr,
                           input logic [31:0] data, input int hold);
    int lat;
    lat = wlat(inst);
    @(negedge clk);
    wv[inst] = 1'b1;
    wa[inst] = addr;
    wd[inst] = data;
    @(posedge clk); #1;
    wa[inst] = $urandom();
    wd[inst] = $urandom();
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      check("wr_ready_timing", 32'(wr[inst]), (k == lat) ? 32'd1 : 32'd0);
    end
    model[inst][addr[7:0]] = data;
    known[inst][addr[7:0]] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("wr_ready_hold", 32'(wr[inst]), 32'd1);
    end
    wv[inst] = 1'b0;
    @(posedge clk); #1;
    check("wr_ready_fall", 32'(wr[inst]), 32'd0);
  endtask

  // Full read transaction, with the same timing checks as write_txn. read_data
  // is checked against the model while ready is high and again after it falls.
  task automatic read_txn(input int inst, input logic [31:0] addr, input int hold);
    int          lat;
    logic [31:0] exp;
    lat = rlat(inst);
    exp = model[inst][addr[7:0]];
    @(negedge clk);
    rv[inst] = 1'b1;
    ra[inst] = addr;
    @(posedge clk); #1;
    ra[inst] = $urandom();
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      check("rd_ready_timing", 32'(rr[inst]), (k == lat) ? 32'd1 : 32'd0);
    end
    check("rd_data", rd[inst], exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("rd_ready_hold", 32'(rr[inst]), 32'd1);
    end
    rv[inst] = 1'b0;
    @(posedge clk); #1;
    check("rd_ready_fall", 32'(rr[inst]), 32'd0);
    check("rd_data_kept", rd[inst], exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          inst;

    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; ra[i] = '0; wv[i] = 1'b0; wa[i] = '0; wd[i] = '0;
      for (int j = 0; j < 256; j++) known[i][j] = 1'b0;
    end

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_rd_ready", 32'(rr[i]), 32'd0);
      check("reset_wr_ready", 32'(wr[i]), 32'd0);
      check("reset_rd_data", rd[i], 32'd0);
    end
    reset_n = 1'b1;

    // 1: write 0x5 <- 0xDEADBEEF, then read it back (defaults)
    write_txn(0, 32'h5, 32'hDEADBEEF, 0);
    read_txn(0, 32'h5, 0);

    // 2: read latency 4, with valid held for a few cycles in RESP
    write_txn(1, 32'h33, 32'hCAFE0033, 1);
    read_txn(1, 32'h33, 3);

    // 3: same-edge read and write of index 7 (latencies 2/2) returns the old word
    write_txn(2, 32'h7, 32'h1111, 0);
    @(negedge clk);
    rv[2] = 1'b1; ra[2] = 32'h7;
    wv[2] = 1'b1; wa[2] = 32'h7; wd[2] = 32'h2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("same_edge_rd_early", 32'(rr[2]), 32'd0);
    check("same_edge_wr_early", 32'(wr[2]), 32'd0);
    @(posedge clk); #1;
    check("same_edge_rd_ready", 32'(rr[2]), 32'd1);
    check("same_edge_wr_ready", 32'(wr[2]), 32'd1);
    check("same_edge_old_data", rd[2], 32'h1111);
    rv[2] = 1'b0; wv[2] = 1'b0;
    @(posedge clk); #1;
    check("same_edge_rd_fall", 32'(rr[2]), 32'd0);
    check("same_edge_wr_fall", 32'(wr[2]), 32'd0);
    model[2][7] = 32'h2222;
    read_txn(2, 32'h7, 0);

    // 4: address wrap-around above the index bits
    write_txn(0, 32'h105, 32'hA5A5, 0);
    read_txn(0, 32'h005, 0);

    // 5: reset while a write is in flight, so the write is dropped
    write_txn(2, 32'h9, 32'h0BAD0009, 0);
    read_txn(2, 32'h7, 0);
    @(negedge clk);
    wv[2] = 1'b1; wa[2] = 32'h9; wd[2] = 32'hFFFF0000;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_ready", 32'(wr[2]), 32'd0);
    check("async_rst_rd_ready", 32'(rr[2]), 32'd0);
    check("async_rst_rd_data", rd[2], 32'd0);
    wv[2] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_txn(2, 32'h9, 0);

    // 6: read_valid dropped one cycle after capture gives a single-cycle pulse
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = 32'h5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    check("drop_rd_not_yet", 32'(rr[0]), 32'd0);
    @(posedge clk); #1;
    check("drop_rd_pulse", 32'(rr[0]), 32'd1);
    check("drop_rd_data", rd[0], model[0][5]);
    @(posedge clk); #1;
    check("drop_rd_pulse_end", 32'(rr[0]), 32'd0);
    read_txn(0, 32'h105, 0);

    // Randomised traffic. Reads use only indices that have been written, and
    // random upper address bits exercise the wrap-around.
    for (int n = 0; n < 60; n++) begin
      inst = int'($urandom_range(0, 2));
      a    = {$urandom_range(0, 32'hFFFFFF), 8'(32'h20 + $urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 0 || !known[inst][a[7:0]])
        write_txn(inst, a, $urandom(), int'($urandom_range(0, 2)));
      else
        read_txn(inst, a, int'($urandom_range(0, 2)));
    end

    // Concurrent read and write captured on the same edge, to different indices
    for (int n = 0; n < 8; n++) begin
      inst = int'($urandom_range(0, 2));
      a    = {24'($urandom()), 8'h40 + 8'(n)};
      b    = {24'($urandom()), 8'h20 + 8'(n)};
      if (!known[inst][b[7:0]]) write_txn(inst, b, $urandom(), 0);
      fork
        write_txn(inst, a, $urandom(), int'($urandom_range(0, 2)));
        read_txn(inst, b, int'($urandom_range(0, 2)));
      join
      read_txn(inst, a, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
